ptr_bank: RTL and testbench
===========================

# ptr_bank

Parametrised bank of NCH independent address-pointer channels, each holding a base register, a limit register and a current pointer. It is the generalised successor of the single row/column pointer register. The bank adds these features:
- Channel selection.
- Increment and decrement.
- Programmable upper bound with wrap-to-base or saturate modes.
- Terminal-count and wrap indications.
- Bank-wide reload.

It sits between the datapath bus (BusOut) and the address/operand pointers used by the control unit.

## Interface
- WIDTH, 8, bit width of base, limit and pointer registers
- NCH, 2, number of channels (1..16)
- CHW, 1, width of channel select; must satisfy 2^CHW >= NCH
- Clk  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset of all state
- Sel  input  CHW  channel addressed by Wen/Wlim/Rld/Inc/Dec and by the read outputs
- BusOut  input  WIDTH  write data from datapath bus
- Wen  input  1  load base and pointer of selected channel from BusOut
- Wlim  input  1  load limit of selected channel from BusOut
- Rld  input  1  reload selected channel pointer from its base
- RldAll  input  1  reload every channel pointer from its own base
- Inc  input  1  step selected pointer +1
- Dec  input  1  step selected pointer -1
- Mode  input  1  0 = wrap at bounds, 1 = saturate at bounds
- dout  output  WIDTH  pointer of selected channel
- rbase  output  WIDTH  base of selected channel
- tc  output  1  selected pointer equals its limit
- wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge

## Operation
- State per channel: ptr[WIDTH], base[WIDTH], lim[WIDTH]. The bank also holds one wrap flop.
- Reset (RST high, async): every ptr = 0, every base = 0, every lim = 2^WIDTH-1, wrap = 0. State is held while RST is high. Reset mid-sequence discards all in-flight operations.
- The read outputs are combinational muxes of the registers of channel Sel: dout = ptr[Sel], rbase = base[Sel], tc = (ptr[Sel] == lim[Sel]).
- If Sel >= NCH, all writes and pointer ops are ignored. dout, rbase and tc then read 0.
- Limit write: Wlim sets lim[Sel] = BusOut. It is independent of pointer priority, and may coincide with Wen (both take BusOut).
- Pointer update priority for the selected channel, highest first:
  1. Wen: base[Sel] = BusOut and ptr[Sel] = BusOut. Unconditional; there is no pointer-equals-zero condition.
  2. Rld or RldAll: ptr = base.
  3. Inc xor Dec: step the pointer.
  4. Inc and Dec together, or neither: hold.
- RldAll reloads all non-selected channels every cycle it is asserted. For the selected channel, a simultaneous Wen still wins.
- Inc on a channel:
  - ptr != lim: ptr+1 mod 2^WIDTH.
  - ptr == lim and Mode=0: ptr = base, wrap pulse.
  - ptr == lim and Mode=1: hold, no pulse.
- Dec on a channel:
  - ptr != base: ptr-1 mod 2^WIDTH.
  - ptr == base and Mode=0: ptr = lim, wrap pulse.
  - ptr == base and Mode=1: hold, no pulse.
- Base and limit comparisons are equality only. If base > lim, Inc still counts through 2^WIDTH-1 to 0 until it reaches lim; there is no error.
- If base == lim, the channel is constant under Inc/Dec. In Mode=0 every Inc/Dec produces a wrap pulse.
- Non-selected channels hold except under RldAll.

## Timing
- Single-cycle: every update is visible on dout/rbase/tc immediately after the capturing rising edge. There is no handshake and no stall.
- wrap is high for exactly the one cycle following an edge at which a wrap occurred. Consecutive wraps give consecutive high cycles.
- tc and dout follow Sel combinationally within the same cycle, so changing Sel re-reads without an edge.
- The RST assertion clears outputs without waiting for Clk. After RST deassertion, the first edge performs normal operation.

## Test plan
- Reset: assert RST mid-count, no Clk edge -> dout=0, rbase=0, wrap=0; with Sel=0 and ptr=0 against lim=255, tc=0. Then write lim=0 -> tc=1.
- Load and count, WIDTH=8: Sel=1, Wen with BusOut=0x10, Wlim with BusOut=0x12, Mode=0, Inc for 3 cycles -> dout 0x11, 0x12 (tc=1), 0x10 with wrap=1 in the following cycle.
- Saturate and decrement: channel base=0x05, lim=0x07, ptr=0x05, Mode=1, Dec -> dout stays 0x05, wrap=0. Mode=0, Dec -> dout=0x07, wrap pulse.
- Priority: ptr=0x30, base=0x20, assert Wen(BusOut=0x40)+Rld+Inc -> dout=0x40, rbase=0x40. Next cycle Rld+Inc -> 0x40. Next cycle Inc+Dec -> holds 0x40.
- Bank reload: channels 0 and 1 at ptr 0x03 and 0x09 with bases 0x00 and 0x08. RldAll with Sel=0 and Wen(BusOut=0x55) -> ch0 ptr=0x55, ch1 ptr=0x08.
- Rollover and out-of-range: base=0xFE, lim=0x01, Mode=0, Inc x4 -> 0xFF, 0x00, 0x01, 0xFE (wrap pulse). With NCH=3 and CHW=2, Sel=3 with Wen -> no state change, dout=0.

Source files
------------

// File: rtl/ptr_bank.sv
// Bank of NCH address-pointer channels (base, limit, pointer) with
// wrap/saturate stepping, per-channel and bank-wide reload.
module ptr_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CHW   = 1
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic [CHW-1:0]   Sel,
    input  logic [WIDTH-1:0] BusOut,
    input  logic             Wen,
    input  logic             Wlim,
    input  logic             Rld,
    input  logic             RldAll,
    input  logic             Inc,
    input  logic             Dec,
    input  logic             Mode,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rbase,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] ptr_q  [NCH];
    logic [WIDTH-1:0] ptr_d  [NCH];
    logic [WIDTH-1:0] base_q [NCH];
    logic [WIDTH-1:0] base_d [NCH];
    logic [WIDTH-1:0] lim_q  [NCH];
    logic [WIDTH-1:0] lim_d  [NCH];
    logic             wrap_q;
    logic             wrap_d;

    // A Sel value with no matching channel index touches nothing and reads 0.
    always_comb begin
        wrap_d = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            ptr_d[ch]  = ptr_q[ch];
            base_d[ch] = base_q[ch];
            lim_d[ch]  = lim_q[ch];
            if (Sel == CHW'(ch)) begin
                if (Wlim) begin
                    lim_d[ch] = BusOut;
                end
                if (Wen) begin
                    base_d[ch] = BusOut;
                    ptr_d[ch]  = BusOut;
                end else if (Rld || RldAll) begin
                    ptr_d[ch] = base_q[ch];
                end else if (Inc && !Dec) begin
                    if (ptr_q[ch] != lim_q[ch]) begin
                        ptr_d[ch] = ptr_q[ch] + WIDTH'(1);
                    end else if (!Mode) begin
                        ptr_d[ch] = base_q[ch];
                        wrap_d    = 1'b1;
                    end
                end else if (Dec && !Inc) begin
                    if (ptr_q[ch] != base_q[ch]) begin
                        ptr_d[ch] = ptr_q[ch] - WIDTH'(1);
                    end else if (!Mode) begin
                        ptr_d[ch] = lim_q[ch];
                        wrap_d    = 1'b1;
                    end
                end
            end else if (RldAll) begin
                ptr_d[ch] = base_q[ch];
            end
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            for (int ch = 0; ch < NCH; ch++) begin
                ptr_q[ch]  <= '0;
                base_q[ch] <= '0;
                lim_q[ch]  <= '1;
            end
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            base_q <= base_d;
            lim_q  <= lim_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        dout  = '0;
        rbase = '0;
        tc    = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (Sel == CHW'(ch)) begin
                dout  = ptr_q[ch];
                rbase = base_q[ch];
                tc    = (ptr_q[ch] == lim_q[ch]);
            end
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_ptr_bank.sv
// Self-checking bench for ptr_bank (WIDTH=8, NCH=3, CHW=2): vector table
// with a scoreboard queue, plus hand sequences for async reset and Sel re-read.
`timescale 1ns/1ps
module tb_ptr_bank;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int CHW   = 2;

    logic             Clk = 1'b0;
    logic             RST;
    logic [CHW-1:0]   Sel;
    logic [WIDTH-1:0] BusOut;
    logic             Wen, Wlim, Rld, RldAll, Inc, Dec, Mode;
    logic [WIDTH-1:0] dout, rbase;
    logic             tc, wrap;

    ptr_bank #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) dut (
        .Clk(Clk), .RST(RST), .Sel(Sel), .BusOut(BusOut),
        .Wen(Wen), .Wlim(Wlim), .Rld(Rld), .RldAll(RldAll),
        .Inc(Inc), .Dec(Dec), .Mode(Mode),
        .dout(dout), .rbase(rbase), .tc(tc), .wrap(wrap)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic [CHW-1:0]   sel;
        logic [WIDTH-1:0] bus;
        logic             wen, wlim, rld, rldall, inc, dec, mode;
        logic [WIDTH-1:0] e_dout, e_rbase;
        logic             e_tc, e_wrap;
    } vec_t;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] dout, rbase;
        logic             tc, wrap;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic [CHW-1:0] s, input logic [WIDTH-1:0] b,
                                input logic we, input logic wl, input logic rl,
                                input logic ra, input logic in, input logic de,
                                input logic md, input logic [WIDTH-1:0] ed,
                                input logic [WIDTH-1:0] eb, input logic et,
                                input logic ew);
        vec_t v;
        v.sel = s; v.bus = b; v.wen = we; v.wlim = wl; v.rld = rl;
        v.rldall = ra; v.inc = in; v.dec = de; v.mode = md;
        v.e_dout = ed; v.e_rbase = eb; v.e_tc = et; v.e_wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        BusOut = '0; Wen = 0; Wlim = 0; Rld = 0; RldAll = 0;
        Inc = 0; Dec = 0; Mode = 0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        Sel = v.sel; BusOut = v.bus; Wen = v.wen; Wlim = v.wlim; Rld = v.rld;
        RldAll = v.rldall; Inc = v.inc; Dec = v.dec; Mode = v.mode;
        e.idx = idx; e.dout = v.e_dout; e.rbase = v.e_rbase;
        e.tc = v.e_tc; e.wrap = v.e_wrap;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        got = sb_q.pop_front();
        check("dout",  got.idx, dout,  got.dout);
        check("rbase", got.idx, rbase, got.rbase);
        check("tc",    got.idx, WIDTH'(tc),   WIDTH'(got.tc));
        check("wrap",  got.idx, WIDTH'(wrap), WIDTH'(got.wrap));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Sel = '0; idle_inputs();
        repeat (2) @(negedge Clk);
        check("rst_dout", 0, dout, 8'h00);
        check("rst_tc",   0, WIDTH'(tc), 8'h00);
        check("rst_wrap", 0, WIDTH'(wrap), 8'h00);
        RST = 1'b0;

        //                 sel bus   we wl rl ra in de md   dout  rbase tc wr
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
        // load and count on channel 1
        tbl.push_back(mk(1, 8'h10, 1, 0, 0, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h11, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h12, 8'h10, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h10, 8'h10, 0, 1));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0));
        // saturate and decrement on channel 2
        tbl.push_back(mk(2, 8'h05, 1, 1, 0, 0, 0, 0, 0, 8'h05, 8'h05, 1, 0));
        tbl.push_back(mk(2, 8'h07, 0, 1, 0, 0, 0, 0, 0, 8'h05, 8'h05, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h05, 8'h05, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h07, 8'h05, 1, 1));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h06, 8'h05, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h07, 8'h05, 1, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h07, 8'h05, 1, 0));
        // priority on channel 0: ptr 0x30, base 0x20
        tbl.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h20, 1, 0, 0, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'(8'h20 + i), 8'h20, 0, 0));
        tbl.push_back(mk(0, 8'h40, 1, 0, 1, 0, 1, 0, 0, 8'h40, 8'h40, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h40, 8'h40, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h40, 8'h40, 0, 0));
        // bank reload: ch0 ptr 3 base 0, ch1 ptr 9 base 8
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h03, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h08, 1, 0, 0, 0, 0, 0, 0, 8'h08, 8'h08, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h09, 8'h08, 0, 0));
        tbl.push_back(mk(0, 8'h55, 1, 0, 0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h08, 8'h08, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h05, 8'h05, 0, 0));
        // rollover with base > lim on channel 2
        tbl.push_back(mk(2, 8'hFE, 1, 0, 0, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h01, 0, 1, 0, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'hFF, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'hFE, 1, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'hFE, 8'hFE, 0, 1));
        // out-of-range select
        tbl.push_back(mk(3, 8'hAA, 1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0));
        // drive channel 2 to a wrap so the async reset below clears a live pulse
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'hFF, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hFE, 0, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'hFE, 1, 0));
        tbl.push_back(mk(2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'hFE, 8'hFE, 0, 1));

        foreach (tbl[i]) apply(tbl[i], i);

        // Sel re-read without an edge (now at posedge + 1)
        idle_inputs();
        Sel = 2'd1;
        #1;
        check("sel_dout",  0, dout,  8'h08);
        check("sel_rbase", 0, rbase, 8'h08);
        Sel = 2'd2;
        #1;
        check("pre_rst_wrap", 0, WIDTH'(wrap), 8'h01);
        RST = 1'b1;
        #1;
        check("async_dout",  0, dout,  8'h00);
        check("async_rbase", 0, rbase, 8'h00);
        check("async_wrap",  0, WIDTH'(wrap), 8'h00);
        check("async_tc",    0, WIDTH'(tc), 8'h00);
        Sel = 2'd0;
        Inc = 1'b1;
        #1;
        check("async_tc_sel0", 0, WIDTH'(tc), 8'h00);
        @(posedge Clk);
        #1;
        check("rst_hold_dout", 0, dout, 8'h00);
        @(negedge Clk);
        RST = 1'b0;
        idle_inputs();
        apply(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0), 1000);
        apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 1), 1001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
